// File: rtl/snake_body_buffer.sv
// snake_body_buffer: owns the snake's segment list in tile coordinates.
// Each accepted step computes a candidate head and checks it against the walls.
// It then scans the body one segment per cycle for self collision.
// Finally it shifts the body and publishes packed x/y arrays for the display.
// Unused slots hold all-ones, which the display treats as "no segment".
//
// Handshake: a step is accepted on a rising edge where step_valid && step_ready.
// step_ready is high only in IDLE while the game is running. A request made
// while step_ready is low is dropped, not queued.
module snake_body_buffer #(
    parameter int MAX_SEG  = 100,
    parameter int INIT_LEN = 2,
    parameter int GRID_W   = 13,
    parameter int GRID_H   = 9,
    parameter int START_X  = 4,
    parameter int START_Y  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  step_valid,
    input  logic [1:0]            dir,
    input  logic                  grow,
    output logic                  step_ready,
    output logic [MAX_SEG*32-1:0] x_values,
    output logic [MAX_SEG*32-1:0] y_values,
    output logic [31:0]           head_x,
    output logic [31:0]           head_y,
    output logic [7:0]            length,
    output logic                  game_done
);

    localparam logic [7:0]  MAX_SEG_L  = 8'(MAX_SEG);
    localparam logic [7:0]  INIT_LEN_L = 8'(INIT_LEN);
    localparam logic [31:0] X_LAST     = 32'(GRID_W - 1);
    localparam logic [31:0] Y_LAST     = 32'(GRID_H - 1);

    typedef enum logic [1:0] {S_IDLE, S_CHECK, S_COMMIT, S_DEAD} state_t;

    state_t      state_q, state_d;
    logic [31:0] slot_x_q [MAX_SEG];
    logic [31:0] slot_x_d [MAX_SEG];
    logic [31:0] slot_y_q [MAX_SEG];
    logic [31:0] slot_y_d [MAX_SEG];
    logic [7:0]  len_q, len_d;
    logic [1:0]  cur_dir_q, cur_dir_d;
    logic [1:0]  eff_dir_q, eff_dir_d;
    logic [31:0] cand_x_q, cand_x_d;
    logic [31:0] cand_y_q, cand_y_d;
    logic        g_q, g_d;
    logic [7:0]  lim_q, lim_d;
    logic [7:0]  idx_q, idx_d;
    logic        done_q, done_d;

    // Accept-cycle decode, all relative to the current head and direction.
    logic        accept;
    logic [1:0]  eff_dir_acc;
    logic        g_acc;
    logic        wall_hit;
    logic [7:0]  lim_acc;
    logic [31:0] cand_x_acc, cand_y_acc;
    logic        body_hit;
    logic        last_idx;

    // Decode the requested move: reversal filter, candidate head, wall test, scan limit.
    always_comb begin
        accept = step_valid && step_ready;
        if (dir[1] == cur_dir_q[1] && dir[0] != cur_dir_q[0]) eff_dir_acc = cur_dir_q;
        else                                                  eff_dir_acc = dir;
        g_acc      = grow && (len_q < MAX_SEG_L);
        // Without growth the tail vacates this step, so it is left out of the scan.
        lim_acc    = g_acc ? len_q : len_q - 8'd1;
        cand_x_acc = slot_x_q[0];
        cand_y_acc = slot_y_q[0];
        wall_hit   = 1'b0;
        case (eff_dir_acc)
            2'b00: begin cand_y_acc = slot_y_q[0] - 32'd1; wall_hit = (slot_y_q[0] == 32'd0); end
            2'b01: begin cand_y_acc = slot_y_q[0] + 32'd1; wall_hit = (slot_y_q[0] == Y_LAST); end
            2'b10: begin cand_x_acc = slot_x_q[0] - 32'd1; wall_hit = (slot_x_q[0] == 32'd0); end
            default: begin cand_x_acc = slot_x_q[0] + 32'd1; wall_hit = (slot_x_q[0] == X_LAST); end
        endcase
        body_hit = (cand_x_q == slot_x_q[idx_q]) && (cand_y_q == slot_y_q[idx_q]);
        last_idx = (idx_q == lim_q - 8'd1);
    end

    // State and datapath registers, synchronous reset to the starting snake.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            len_q     <= INIT_LEN_L;
            cur_dir_q <= 2'b11;
            eff_dir_q <= 2'b11;
            cand_x_q  <= '0;
            cand_y_q  <= '0;
            g_q       <= 1'b0;
            lim_q     <= '0;
            idx_q     <= '0;
            done_q    <= 1'b0;
            for (int i = 0; i < MAX_SEG; i++) begin
                slot_x_q[i] <= (i < INIT_LEN) ? 32'(START_X - i) : 32'hFFFF_FFFF;
                slot_y_q[i] <= (i < INIT_LEN) ? 32'(START_Y)     : 32'hFFFF_FFFF;
            end
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            cur_dir_q <= cur_dir_d;
            eff_dir_q <= eff_dir_d;
            cand_x_q  <= cand_x_d;
            cand_y_q  <= cand_y_d;
            g_q       <= g_d;
            lim_q     <= lim_d;
            idx_q     <= idx_d;
            done_q    <= done_d;
            for (int i = 0; i < MAX_SEG; i++) begin
                slot_x_q[i] <= slot_x_d[i];
                slot_y_q[i] <= slot_y_d[i];
            end
        end
    end

    // Next-state logic: IDLE -> CHECK -> COMMIT -> IDLE, any collision parks in DEAD.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (wall_hit)           state_d = S_DEAD;
                    else if (lim_acc == '0) state_d = S_COMMIT;
                    else                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (body_hit)      state_d = S_DEAD;
                else if (last_idx) state_d = S_COMMIT;
            end
            S_COMMIT: state_d = S_IDLE;
            default:  state_d = S_DEAD;
        endcase
    end

    // Datapath next values: latch the move, step the scan, and shift the body on commit.
    always_comb begin
        len_d     = len_q;
        cur_dir_d = cur_dir_q;
        eff_dir_d = eff_dir_q;
        cand_x_d  = cand_x_q;
        cand_y_d  = cand_y_q;
        g_d       = g_q;
        lim_d     = lim_q;
        idx_d     = idx_q;
        done_d    = done_q;
        for (int i = 0; i < MAX_SEG; i++) begin
            slot_x_d[i] = slot_x_q[i];
            slot_y_d[i] = slot_y_q[i];
        end
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    cand_x_d  = cand_x_acc;
                    cand_y_d  = cand_y_acc;
                    eff_dir_d = eff_dir_acc;
                    g_d       = g_acc;
                    lim_d     = lim_acc;
                    idx_d     = '0;
                    if (wall_hit) done_d = 1'b1;
                end
            end
            S_CHECK: begin
                if (body_hit) done_d = 1'b1;
                else          idx_d  = idx_q + 8'd1;
            end
            S_COMMIT: begin
                for (int i = MAX_SEG - 1; i > 0; i--) begin
                    slot_x_d[i] = slot_x_q[i-1];
                    slot_y_d[i] = slot_y_q[i-1];
                end
                slot_x_d[0] = cand_x_q;
                slot_y_d[0] = cand_y_q;
                cur_dir_d   = eff_dir_q;
                if (g_q) begin
                    len_d = len_q + 8'd1;
                end else if (len_q < MAX_SEG_L) begin
                    // The old tail copy that the shift pushed into slot[length] is cleared.
                    slot_x_d[len_q] = 32'hFFFF_FFFF;
                    slot_y_d[len_q] = 32'hFFFF_FFFF;
                end
            end
            default: ;
        endcase
    end

    // Outputs: decoded purely from registers, no input-to-output path.
    always_comb begin
        step_ready = (state_q == S_IDLE) && !done_q;
        head_x     = slot_x_q[0];
        head_y     = slot_y_q[0];
        length     = len_q;
        game_done  = done_q;
        for (int i = 0; i < MAX_SEG; i++) begin
            x_values[i*32 +: 32] = slot_x_q[i];
            y_values[i*32 +: 32] = slot_y_q[i];
        end
    end

endmodule
